// File: rtl/spi_sched_if.sv
// Signal bundle between the requesters, the spi_sched scheduler and the 32-bit SPI master.
// The slave modport is the scheduler's view; the master modport is the view of the surrounding logic.
interface spi_sched_if;
  logic [1:0]  Req;
  logic [31:0] TxData0;
  logic [31:0] TxData1;
  logic [1:0]  CsSel0;
  logic [1:0]  CsSel1;
  logic [7:0]  ModeCfg;
  logic [1:0]  Ack;
  logic        Err;
  logic [31:0] RxData;
  logic [3:0]  Cs_n;
  logic        SpiStart;
  logic [31:0] SpiTxData;
  logic        SpiCPol;
  logic        SpiCPha;
  logic [31:0] SpiRxData;
  logic        SpiEndTx;

  modport slave (
    input  Req, TxData0, TxData1, CsSel0, CsSel1, ModeCfg, SpiRxData, SpiEndTx,
    output Ack, Err, RxData, Cs_n, SpiStart, SpiTxData, SpiCPol, SpiCPha
  );

  modport master (
    output Req, TxData0, TxData1, CsSel0, CsSel1, ModeCfg, SpiRxData, SpiEndTx,
    input  Ack, Err, RxData, Cs_n, SpiStart, SpiTxData, SpiCPol, SpiCPha
  );
endinterface

// File: rtl/spi_sched.sv
// Round-robin scheduler for two requesters in front of the SPI master: chip-select timing,
// per-slave mode selection, start pulse, end-of-transfer wait with watchdog, and acknowledge.
module spi_sched #(
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 2,
    parameter int TIMEOUT  = 4096
) (
    input  logic        Clk,
    input  logic        Rst_n,
    spi_sched_if.slave  bus,
    output logic [2:0]  dbg_state
);

    // Handshake: Req[i] is a level that requester i holds until it sees its one-cycle Ack[i];
    // the grant is taken only in IDLE, so Req changes between grant and Ack have no effect.
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_START, S_BUSY, S_HOLD, S_DONE, S_GAP
    } state_t;

    localparam logic [7:0]  SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0]  HOLD_LAST  = 8'(CS_HOLD - 1);
    localparam logic [7:0]  IDLE_LAST  = 8'(CS_IDLE - 1);
    localparam logic [15:0] WD_LAST    = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] wd_q, wd_d;
    logic        last_q, last_d;
    logic        abort_q, abort_d;
    logic [3:0]  cs_n_q, cs_n_d;
    logic [1:0]  ack_q, ack_d;
    logic        err_q, err_d;
    logic        start_q, start_d;
    logic [31:0] rx_q, rx_d;
    logic [31:0] tx_q, tx_d;
    logic        cpol_q, cpol_d;
    logic        cpha_q, cpha_d;
    logic        gnt;
    logic [1:0]  sel;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            wd_q    <= 16'd0;
            last_q  <= 1'b1;
            abort_q <= 1'b0;
            cs_n_q  <= 4'hF;
            ack_q   <= 2'b00;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            rx_q    <= 32'd0;
            tx_q    <= 32'd0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            last_q  <= last_d;
            abort_q <= abort_d;
            cs_n_q  <= cs_n_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            start_q <= start_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        wd_d    = (wd_q == 16'hFFFF) ? wd_q : wd_q + 16'd1;
        last_d  = last_q;
        abort_d = abort_q;
        cs_n_d  = cs_n_q;
        ack_d   = 2'b00;
        err_d   = 1'b0;
        start_d = 1'b0;
        rx_d    = rx_q;
        tx_d    = tx_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        gnt     = 1'b0;
        sel     = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (bus.Req != 2'b00) begin
                    // Contention alternates away from the last winner.
                    gnt              = (bus.Req == 2'b11) ? ~last_q : bus.Req[1];
                    sel              = gnt ? bus.CsSel1 : bus.CsSel0;
                    tx_d             = gnt ? bus.TxData1 : bus.TxData0;
                    {cpol_d, cpha_d} = bus.ModeCfg[{sel, 1'b0} +: 2];
                    cs_n_d           = ~(4'b0001 << sel);
                    last_d           = gnt;
                    cnt_d            = 8'd0;
                    state_d          = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q >= SETUP_LAST) begin
                    start_d = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                wd_d    = 16'd0;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (bus.SpiEndTx) begin
                    rx_d    = bus.SpiRxData;
                    cnt_d   = 8'd0;
                    state_d = S_HOLD;
                end else if (wd_q >= WD_LAST) begin
                    abort_d = 1'b1;
                    rx_d    = 32'd0;
                    cnt_d   = 8'd0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_q >= HOLD_LAST) state_d = S_DONE;
            end
            S_DONE: begin
                ack_d   = last_q ? 2'b10 : 2'b01;
                err_d   = abort_q;
                abort_d = 1'b0;
                cs_n_d  = 4'hF;
                cnt_d   = 8'd0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (cnt_q >= IDLE_LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.Ack       = ack_q;
    assign bus.Err       = err_q;
    assign bus.RxData    = rx_q;
    assign bus.Cs_n      = cs_n_q;
    assign bus.SpiStart  = start_q;
    assign bus.SpiTxData = tx_q;
    assign bus.SpiCPol   = cpol_q;
    assign bus.SpiCPha   = cpha_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_spi_sched.sv
// Bench for spi_sched: directed scenarios plus randomized transactions, checked against a
// transaction-level model of grant order, chip-select timing and returned data.
module tb_spi_sched;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_IDLE  = 2;
  localparam int TIMEOUT  = 16;
  localparam int WAIT_MAX = 400;

  // clock / reset
  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;
  logic [2:0] dbg_state;
  int cyc = 0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  spi_sched_if bus();

  spi_sched #(
    .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .bus(bus.slave), .dbg_state(dbg_state)
  );

  // scoreboard and model state
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rx = 32'd0;
  logic model_last = 1'b1;
  int last_ack_cyc = 0;
  bit have_prev = 1'b0;
  int n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h cyc=%0d state=%0d", tag, obs, exp, cyc, dbg_state);
    end
  endtask

  // driver + model for one transaction; caller sets TxData/CsSel/ModeCfg beforehand
  task automatic run_txn(input logic [1:0] req, input logic [1:0] req_mid,
                         input logic [1:0] req_after, input bit no_end,
                         input int delay, input logic [31:0] rx);
    logic g;
    logic [1:0] sel;
    logic [1:0] mode;
    logic [31:0] tx;
    logic [3:0] cs_exp;
    int t_cs, t_st, t_ack_exp, k, s;
    bit stable;
    g = (req == 2'b11) ? ~model_last : req[1];
    model_last = g;
    sel = g ? bus.CsSel1 : bus.CsSel0;
    tx = g ? bus.TxData1 : bus.TxData0;
    s = int'(sel);
    mode = bus.ModeCfg[2*s +: 2];
    cs_exp = 4'hF & ~(4'h1 << sel);
    exp_q.push_back(no_end ? 32'd0 : rx);

    bus.Req = req;
    k = 0;
    do begin @(negedge Clk); k++; end while (bus.Cs_n === 4'hF && k < WAIT_MAX);
    check("grant_cs", 32'(bus.Cs_n), 32'(cs_exp));
    t_cs = cyc;
    if (have_prev) check("idle_gap", 32'(t_cs - last_ack_cyc >= CS_IDLE + 1), 32'd1);
    check("tx_word", bus.SpiTxData, tx);
    check("cpol", 32'(bus.SpiCPol), 32'(mode[1]));
    check("cpha", 32'(bus.SpiCPha), 32'(mode[0]));

    k = 0;
    while (bus.SpiStart !== 1'b1 && k < WAIT_MAX) begin @(negedge Clk); k++; end
    check("start_delay", 32'(cyc - t_cs), 32'(CS_SETUP));
    t_st = cyc;
    bus.Req = req_mid;
    @(negedge Clk);
    check("start_width", 32'(bus.SpiStart), 32'd0);

    if (!no_end) begin
      repeat (delay) @(negedge Clk);
      bus.SpiEndTx = 1'b1;
      bus.SpiRxData = rx;
      @(negedge Clk);
      bus.SpiEndTx = 1'b0;
      bus.SpiRxData = $urandom;
      t_ack_exp = cyc + CS_HOLD + 1;
      check("rx_after_end", bus.RxData, rx);
    end else begin
      t_ack_exp = t_st + 1 + TIMEOUT + CS_HOLD + 1;
    end

    stable = 1'b1;
    k = 0;
    while (bus.Ack === 2'b00 && k < WAIT_MAX) begin
      if (bus.Cs_n !== cs_exp || bus.SpiTxData !== tx || {bus.SpiCPol, bus.SpiCPha} !== mode)
        stable = 1'b0;
      @(negedge Clk);
      k++;
    end
    check("sel_stable", 32'(stable), 32'd1);
    check("ack_time", 32'(cyc), 32'(t_ack_exp));
    check("ack_value", 32'(bus.Ack), g ? 32'd2 : 32'd1);
    check("err", 32'(bus.Err), 32'(no_end));
    last_rx = exp_q.pop_front();
    check("rx_data", bus.RxData, last_rx);
    check("cs_release", 32'(bus.Cs_n), 32'hF);
    last_ack_cyc = cyc;
    have_prev = 1'b1;
    bus.Req = req_after;
    @(negedge Clk);
    check("ack_width", 32'(bus.Ack), 32'd0);
    check("err_width", 32'(bus.Err), 32'd0);
  endtask

  task automatic randomize_inputs();
    bus.TxData0 = $urandom;
    bus.TxData1 = $urandom;
    bus.CsSel0  = 2'($urandom_range(0, 3));
    bus.CsSel1  = 2'($urandom_range(0, 3));
    bus.ModeCfg = 8'($urandom_range(0, 255));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    bus.Req = 2'b00;
    bus.TxData0 = 32'd0;
    bus.TxData1 = 32'd0;
    bus.CsSel0 = 2'd0;
    bus.CsSel1 = 2'd0;
    bus.ModeCfg = 8'd0;
    bus.SpiRxData = 32'd0;
    bus.SpiEndTx = 1'b0;

    // reset values
    repeat (3) @(negedge Clk);
    check("rst_cs", 32'(bus.Cs_n), 32'hF);
    check("rst_ack", 32'(bus.Ack), 32'd0);
    check("rst_err", 32'(bus.Err), 32'd0);
    check("rst_start", 32'(bus.SpiStart), 32'd0);
    check("rst_rx", bus.RxData, 32'd0);
    check("rst_tx", bus.SpiTxData, 32'd0);
    check("rst_cpol", 32'(bus.SpiCPol), 32'd0);
    check("rst_cpha", 32'(bus.SpiCPha), 32'd0);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);

    // directed single transaction to slave 2 in mode CPol=1/CPha=0
    bus.CsSel0 = 2'd2;
    bus.ModeCfg = 8'b0010_0000;
    bus.TxData0 = 32'hA5A5_0F0F;
    run_txn(2'b01, 2'b01, 2'b00, 1'b0, 4, 32'h1234_5678);

    // watchdog abort, then a normal transfer
    randomize_inputs();
    run_txn(2'b10, 2'b10, 2'b00, 1'b1, 0, 32'd0);
    randomize_inputs();
    run_txn(2'b01, 2'b01, 2'b00, 1'b0, 2, $urandom);

    // requester 1 appears mid-transfer and is served next
    randomize_inputs();
    run_txn(2'b01, 2'b11, 2'b10, 1'b0, 6, $urandom);
    randomize_inputs();
    run_txn(2'b10, 2'b10, 2'b00, 1'b0, 3, $urandom);

    // spurious end-of-transfer in GAP and in IDLE
    bus.SpiRxData = ~last_rx;
    bus.SpiEndTx = 1'b1;
    @(negedge Clk);
    bus.SpiEndTx = 1'b0;
    check("spur_gap_rx", bus.RxData, last_rx);
    check("spur_gap_cs", 32'(bus.Cs_n), 32'hF);
    check("spur_gap_ack", 32'(bus.Ack), 32'd0);
    repeat (4) @(negedge Clk);
    bus.SpiEndTx = 1'b1;
    @(negedge Clk);
    bus.SpiEndTx = 1'b0;
    check("spur_idle_rx", bus.RxData, last_rx);
    check("spur_idle_cs", 32'(bus.Cs_n), 32'hF);
    randomize_inputs();
    run_txn(2'b01, 2'b01, 2'b00, 1'b0, 1, $urandom);

    // randomized traffic
    for (int i = 0; i < 8; i++) begin
      randomize_inputs();
      run_txn(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), 2'b00, 1'b0,
              $urandom_range(1, 20), $urandom);
    end

    // reset in the middle of a transfer
    randomize_inputs();
    bus.Req = 2'b01;
    n = 0;
    while (bus.SpiStart !== 1'b1 && n < WAIT_MAX) begin @(negedge Clk); n++; end
    check("rst_mid_started", 32'(bus.SpiStart), 32'd1);
    repeat (3) @(negedge Clk);
    check("rst_mid_cs_low", 32'(bus.Cs_n != 4'hF), 32'd1);
    Rst_n = 1'b0;
    #1;
    check("rst_mid_cs", 32'(bus.Cs_n), 32'hF);
    check("rst_mid_start", 32'(bus.SpiStart), 32'd0);
    check("rst_mid_ack", 32'(bus.Ack), 32'd0);
    bus.Req = 2'b11;
    bus.SpiEndTx = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("rst_hold_ack", 32'(bus.Ack), 32'd0);
    end
    bus.SpiEndTx = 1'b0;
    model_last = 1'b1;
    have_prev = 1'b0;
    Rst_n = 1'b1;

    // both requesters held: grants alternate starting with requester 0
    for (int i = 0; i < 4; i++) begin
      randomize_inputs();
      run_txn(2'b11, 2'b11, (i == 3) ? 2'b00 : 2'b11, 1'b0, $urandom_range(1, 10), $urandom);
    end

    repeat (5) @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
